// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared bus-state encoding and default timing constants for
//               the I2C pad front end.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam logic [0:0] BUS_IDLE = 1'b0;
    localparam logic [0:0] BUS_BUSY = 1'b1;

    localparam int c_FILTER_LEN     = 3;
    localparam int c_HOLD_CYCLES    = 2;
    localparam int c_TIMEOUT_CYCLES = 1000;

endpackage
`default_nettype wire

// File: rtl/i2c_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_glitch_filter
// Description : Two-flop synchroniser followed by a stable-count deglitcher;
//               output idles high.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = c_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_dout
);

    localparam logic [3:0] c_LAST = 4'(FILTER_LEN - 1);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_filt;
    logic       w_sync;

    assign w_sync = r_sync[1];
    assign o_dout = r_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_cnt  <= 4'd0;
            r_filt <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_din};
            if (w_sync == r_filt) begin
                r_cnt <= 4'd0;
            end else if (r_cnt == c_LAST) begin
                r_filt <= w_sync;
                r_cnt  <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_frontend.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_frontend
// Description : Filtered SCL/SDA, edge and START/STOP strobes, bus busy
//               tracking with stuck-bus timeout, held SDA pull-down control.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_frontend
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN     = c_FILTER_LEN,
    parameter int HOLD_CYCLES    = c_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic scl_pad,
    input  logic sda_pad,
    input  logic sda_drive,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic timeout,
    output logic sda_oe
);

    localparam logic [3:0]  c_HOLD    = 4'(HOLD_CYCLES);
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

    logic        r_scl_prev;
    logic        r_sda_prev;
    logic [0:0]  r_state;
    logic [15:0] r_to_cnt;
    logic [3:0]  r_hold;
    logic        r_oe;

    logic w_busy;
    logic w_start;
    logic w_stop;
    logic w_to_hit;

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .rst    (rst),
        .i_din  (scl_pad),
        .o_dout (scl_f)
    );

    i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .rst    (rst),
        .i_din  (sda_pad),
        .o_dout (sda_f)
    );

    // SCL must be stable high across both cycles, so a simultaneous SCL/SDA flip is ignored
    assign w_start  = r_scl_prev & scl_f & r_sda_prev & ~sda_f;
    assign w_stop   = r_scl_prev & scl_f & ~r_sda_prev & sda_f;
    assign w_busy   = (r_state == BUS_BUSY);
    assign w_to_hit = w_busy & (r_to_cnt == c_TIMEOUT);

    assign scl_rise  = scl_f & ~r_scl_prev;
    assign scl_fall  = ~scl_f & r_scl_prev;
    assign start_det = ena & w_start;
    assign stop_det  = ena & w_stop;
    assign bus_busy  = ena & w_busy;
    assign timeout   = ena & w_to_hit;
    assign sda_oe    = r_oe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_state    <= BUS_IDLE;
            r_to_cnt   <= 16'd0;
            r_hold     <= 4'd0;
            r_oe       <= 1'b0;
        end else begin
            r_scl_prev <= scl_f;
            r_sda_prev <= sda_f;

            if (!ena) begin
                r_state <= BUS_IDLE;
            end else if (w_busy) begin
                if (w_stop || w_to_hit) r_state <= BUS_IDLE;
            end else if (w_start) begin
                r_state <= BUS_BUSY;
            end

            if (!ena || !w_busy || w_to_hit || w_stop || w_start || scl_rise || scl_fall)
                r_to_cnt <= 16'd0;
            else
                r_to_cnt <= r_to_cnt + 16'd1;

            if (scl_fall)
                r_hold <= c_HOLD;
            else if (!scl_f && r_hold != 4'd0)
                r_hold <= r_hold - 4'd1;

            // the scl_fall cycle itself is excluded so the hold window starts cleanly
            if (!ena || !w_busy || w_stop || w_to_hit)
                r_oe <= 1'b0;
            else if (!scl_f && !scl_fall && r_hold == 4'd0)
                r_oe <= sda_drive;
        end
    end

endmodule
`default_nettype wire

// File: doc/i2c_bus_frontend.md
Name: i2c_bus_frontend

Overview:
Pad-side front end that feeds the I2C slave FSM. It synchronises and deglitches raw SCL/SDA into the system clock domain and emits single-cycle SCL edge strobes and START/STOP detections. It tracks bus busy/idle with a stuck-bus timeout, and drives the open-drain SDA pull-down (ACK/read data) with a guaranteed hold time after SCL falls.

Parameters:
FILTER_LEN, 3, consecutive clk cycles a synchronised input must differ from its filtered value before the filtered value flips (1..15)
HOLD_CYCLES, 2, clk cycles after scl_fall before sda_oe may change (0..15)
TIMEOUT_CYCLES, 1000, clk cycles without any SCL edge while busy before forced release (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ena  in  1  block enable; low forces bus state IDLE and suppresses strobes
scl_pad  in  1  raw SCL from pad
sda_pad  in  1  raw SDA from pad
sda_drive  in  1  downstream request to pull SDA low (1 = low)
scl_f  out  1  filtered SCL
sda_f  out  1  filtered SDA
scl_rise  out  1  one-cycle pulse, first cycle scl_f is 1 after being 0
scl_fall  out  1  one-cycle pulse, first cycle scl_f is 0 after being 1
start_det  out  1  one-cycle pulse on START or repeated START
stop_det  out  1  one-cycle pulse on STOP
bus_busy  out  1  1 between START and STOP/timeout
timeout  out  1  one-cycle pulse when stuck-bus timeout fires
sda_oe  out  1  pad pull-down enable (1 = drive SDA low)

Behaviour:
- Reset (clk edge with rst=1): sync flops, scl_f and sda_f = 1; all pulses, bus_busy, sda_oe = 0; all counters = 0. Reset mid-transfer releases SDA on the next clk edge.
- Sync: 2-flop synchroniser per line, reset value 1.
- Filter: per line, a counter increments while sync value != filtered value and clears when equal. When the counter reaches FILTER_LEN, the filtered value flips and the counter clears. A clean pad step appears on scl_f/sda_f 2+FILTER_LEN cycles later. A glitch shorter than FILTER_LEN cycles never propagates. Filters run regardless of ena.
- Edges: registered compare of scl_f against its previous value. Strobes are coincident with the new scl_f value.
- START: sda_f 1->0 while scl_f is 1 in both the current and previous cycle. STOP: sda_f 0->1 under the same SCL condition. If SCL and SDA flip in the same cycle, neither is reported.
- Bus FSM, two states:
  - IDLE -> BUSY on START.
  - BUSY -> IDLE on STOP, or when the timeout counter reaches TIMEOUT_CYCLES.
  - START while BUSY is a repeated start: pulse start_det, stay BUSY, clear the timeout counter.
  - ena=0: state forced IDLE, start_det/stop_det/timeout held 0. scl_rise/scl_fall/scl_f/sda_f still valid.
- Timeout counter: active only in BUSY; cleared on any scl_rise/scl_fall and on entry to BUSY. On reaching TIMEOUT_CYCLES: pulse timeout for 1 cycle, go IDLE, force sda_oe=0.
- SDA driver:
  - A hold counter is loaded with HOLD_CYCLES on scl_fall and counts down while scl_f=0.
  - While scl_f=0 and the counter is 0, sda_oe <= sda_drive each cycle (1-cycle latency).
  - While scl_f=1 or the counter is nonzero, sda_oe is frozen.
  - HOLD_CYCLES=0: update is allowed in the cycle after scl_fall.
  - sda_oe is forced 0 in IDLE, on stop_det, on timeout, and when ena=0.
- Own drive does not produce false START: sda_oe only changes with scl_f=0.

Decomposition:
- Shared package i2c_pkg: bus state enum (BUS_IDLE, BUS_BUSY), default FILTER_LEN/HOLD_CYCLES/TIMEOUT_CYCLES constants.
- One sub-module, i2c_glitch_filter (sync + stable-count filter, parameter FILTER_LEN, reset value 1), instantiated for SCL and SDA.
- Edge/condition detect, bus FSM, timeout and SDA driver stay in the top.

Test Plan:
- Reset then idle-high pads for 20 cycles -> scl_f=sda_f=1, no pulses, bus_busy=0, sda_oe=0.
- Glitch: scl_pad low for 2 cycles (FILTER_LEN=3) -> scl_f stays 1, no scl_fall. scl_pad low for 3+ cycles -> scl_fall exactly 5 cycles after the pad edge.
- SDA falls with SCL high, later SDA rises with SCL high -> start_det pulse and bus_busy=1, then stop_det pulse and bus_busy=0. Second START before STOP -> start_det pulse with bus_busy staying 1.
- SCL and SDA pads fall on the same clk -> no start_det.
- bus_busy=1, sda_drive=1 asserted while SCL high -> sda_oe stays 0 until HOLD_CYCLES=2 cycles after scl_fall, then 1 a cycle later. stop_det -> sda_oe=0.
- TIMEOUT_CYCLES=50, START then SCL frozen -> timeout pulse at cycle 50 after the last SCL edge, bus_busy=0, sda_oe=0. Assert rst mid-transfer -> all outputs at reset values next cycle.
